rgb_sequence_monitor: RTL and testbench

// Reader side of the RGB LED colour-cycle interface: watches red/green/blue lines driven by the

---
 rtl/rgb_sequence_monitor.sv | 160 ++++++++++++++++
 tb/tb_rgb_sequence_monitor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_sequence_monitor.sv
// rgb_sequence_monitor: decodes the RGB LED lines to a colour index and checks rotation order and
// per-colour dwell, reporting lock and errors. Define RGB_MON_DWELL_OUT_EN to add last_dwell.
module rgb_sequence_monitor #(
    parameter int  STATE_INTERVAL = 2000000,
    parameter int  TOLERANCE      = 2,
    parameter int  LOCK_COUNT     = 6,
    localparam int DWELL_MAX      = STATE_INTERVAL + TOLERANCE + 1,
    localparam int DW             = $clog2(STATE_INTERVAL + TOLERANCE + 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          red,
    input  logic          green,
    input  logic          blue,
    output logic [2:0]    colour,
    output logic          colour_valid,
    output logic          step,
    output logic          seq_err,
    output logic          dwell_err,
    output logic          locked,
    output logic [15:0]   rotations
`ifdef RGB_MON_DWELL_OUT_EN
    ,
    output logic [DW-1:0] last_dwell
`endif
);

    typedef enum logic [1:0] {
        S_SEARCH,
        S_TRACK,
        S_LOCKED
    } state_t;

    localparam int         GW          = $clog2(LOCK_COUNT + 1);
    localparam logic [2:0] IDX_MAGENTA = 3'd5;
    localparam logic [2:0] IDX_NONE    = 3'd7;

    state_t        state, state_next;
    logic [2:0]    code_q, last_code;
    logic [DW-1:0] dwell_cnt;
    logic [GW-1:0] good_cnt;

    logic [2:0] new_idx, old_idx, old_succ;
    logic       changed, new_legal, old_legal, in_order, dwell_ok, timeout, illegal_entry;
    logic       step_d, seq_err_d, dwell_err_d, rotate_d;

    function automatic logic [2:0] decode(input logic [2:0] code);
        case (code)
            3'b100:  return 3'd0;
            3'b110:  return 3'd1;
            3'b010:  return 3'd2;
            3'b011:  return 3'd3;
            3'b001:  return 3'd4;
            3'b101:  return 3'd5;
            default: return IDX_NONE;
        endcase
    endfunction

    // A change is seen one cycle after it lands in code_q; dwell_cnt then holds the old code's dwell.
    assign new_idx       = decode(code_q);
    assign old_idx       = decode(last_code);
    assign new_legal     = (new_idx != IDX_NONE);
    assign old_legal     = (old_idx != IDX_NONE);
    assign changed       = (code_q != last_code);
    assign old_succ      = (old_idx == IDX_MAGENTA) ? 3'd0 : old_idx + 3'd1;
    assign in_order      = new_legal && old_legal && (new_idx == old_succ);
    assign dwell_ok      = (dwell_cnt >= DW'(STATE_INTERVAL - TOLERANCE)) &&
                           (dwell_cnt <= DW'(STATE_INTERVAL + TOLERANCE));
    assign timeout       = !changed && (dwell_cnt == DW'(DWELL_MAX - 1));
    assign illegal_entry = changed && !new_legal && old_legal;
    assign locked        = (state == S_LOCKED);

    always_ff @(posedge clk) begin
        if (reset) state <= S_SEARCH;
        else       state <= state_next;
    end

    // NOTE: every variable driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_SEARCH: if (changed && new_legal) state_next = S_TRACK;
            S_TRACK: begin
                if (changed) begin
                    if (!(in_order && dwell_ok))             state_next = S_SEARCH;
                    else if (good_cnt == GW'(LOCK_COUNT - 1)) state_next = S_LOCKED;
                end else if (timeout) begin
                    state_next = S_SEARCH;
                end
            end
            S_LOCKED: begin
                if (changed) begin
                    if (!(in_order && dwell_ok)) state_next = S_SEARCH;
                end else if (timeout) begin
                    state_next = S_SEARCH;
                end
            end
            default: state_next = S_SEARCH;
        endcase
    end

    // A wrong successor outranks a bad dwell; an illegal code is always a wrong successor.
    always_comb begin
        step_d      = 1'b0;
        seq_err_d   = 1'b0;
        dwell_err_d = 1'b0;
        rotate_d    = 1'b0;
        if (state != S_SEARCH) begin
            if (changed) begin
                if (!in_order)      seq_err_d   = 1'b1;
                else if (!dwell_ok) dwell_err_d = 1'b1;
                else begin
                    step_d   = 1'b1;
                    rotate_d = (state == S_LOCKED) && (old_idx == IDX_MAGENTA);
                end
            end else if (timeout) begin
                dwell_err_d = 1'b1;
            end
        end else if (illegal_entry) begin
            seq_err_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            code_q       <= '0;
            last_code    <= '0;
            dwell_cnt    <= '0;
            good_cnt     <= '0;
            colour       <= IDX_NONE;
            colour_valid <= 1'b0;
            step         <= 1'b0;
            seq_err      <= 1'b0;
            dwell_err    <= 1'b0;
            rotations    <= '0;
        end else begin
            code_q    <= {red, green, blue};
            last_code <= code_q;
            if (changed)                          dwell_cnt <= DW'(1);
            else if (dwell_cnt != DW'(DWELL_MAX)) dwell_cnt <= dwell_cnt + DW'(1);
            if (state_next == S_SEARCH)           good_cnt  <= '0;
            else if (state == S_TRACK && step_d)  good_cnt  <= good_cnt + GW'(1);
            colour       <= new_idx;
            colour_valid <= new_legal;
            step         <= step_d;
            seq_err      <= seq_err_d;
            dwell_err    <= dwell_err_d;
            if (rotate_d) rotations <= rotations + 16'd1;
        end
    end

`ifdef RGB_MON_DWELL_OUT_EN
    always_ff @(posedge clk) begin
        if (reset)        last_dwell <= '0;
        else if (changed) last_dwell <= dwell_cnt;
    end
`endif

endmodule

// File: tb/tb_rgb_sequence_monitor.sv
// Bench for rgb_sequence_monitor: a table of {code, hold, expected reaction} vectors; per-cycle
// expectations are queued as each code is driven and compared when the DUT output appears.
module tb_rgb_sequence_monitor;

    localparam int SI   = 10;
    localparam int TOL  = 1;
    localparam int LOCK = 3;
    localparam int DMAX = SI + TOL + 1;
    localparam int NONE = -1;

    localparam logic [2:0] RED = 3'b100, YEL = 3'b110, GRN = 3'b010, CYN = 3'b011;
    localparam logic [2:0] BLU = 3'b001, MAG = 3'b101, BLK = 3'b000, WHT = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        red, green, blue;
    logic [2:0]  colour;
    logic        colour_valid, step, seq_err, dwell_err, locked;
    logic [15:0] rotations;
`ifdef RGB_MON_DWELL_OUT_EN
    logic [3:0]  last_dwell;
`endif

    typedef struct {
        logic [2:0]  rgb;
        int          hold;
        logic        step;
        logic        seq_err;
        logic        dwell_err;
        int          tmo;
        logic        locked;
        logic [15:0] rot;
    } vec_t;

    typedef struct {
        int          vec;
        int          cyc;
        logic [39:0] outs;
        logic        chk_ld;
        logic [3:0]  ld;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_vec     = 0;
    int   n_bad     = 0;
    bit   mon_en    = 1'b0;
    int   prev_hold = 0;
    int   split;

    always #5 clk = ~clk;

    rgb_sequence_monitor #(
        .STATE_INTERVAL(SI),
        .TOLERANCE     (TOL),
        .LOCK_COUNT    (LOCK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .colour      (colour),
        .colour_valid(colour_valid),
        .step        (step),
        .seq_err     (seq_err),
        .dwell_err   (dwell_err),
        .locked      (locked),
        .rotations   (rotations)
`ifdef RGB_MON_DWELL_OUT_EN
        ,
        .last_dwell  (last_dwell)
`endif
    );

    // One nibble per single-bit/3-bit field so the hex dump reads field by field.
    function automatic logic [39:0] pack(input logic [2:0] c, input logic v, input logic st,
                                         input logic sq, input logic dw, input logic lk,
                                         input logic [15:0] r);
        return {1'b0, c, 3'b0, v, 3'b0, st, 3'b0, sq, 3'b0, dw, 3'b0, lk, r};
    endfunction

    // Returns {valid, colour index}.
    function automatic logic [3:0] exp_colour(input logic [2:0] rgb);
        case (rgb)
            RED:     return 4'h8;
            YEL:     return 4'h9;
            GRN:     return 4'hA;
            CYN:     return 4'hB;
            BLU:     return 4'hC;
            MAG:     return 4'hD;
            default: return 4'h7;
        endcase
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] rgb, input int hold, input logic st, input logic sq,
                       input logic dw, input int tmo, input logic lk, input int rot);
        vec_t v;
        v.rgb = rgb; v.hold = hold; v.step = st; v.seq_err = sq; v.dwell_err = dw;
        v.tmo = tmo; v.locked = lk; v.rot = 16'(rot);
        vecs.push_back(v);
    endtask

    task automatic apply_reset();
        mon_en = 1'b0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        {red, green, blue} = BLK;
        @(negedge clk);
        check("reset first edge [colour valid step seq_err dwell_err locked rotations]",
              pack(colour, colour_valid, step, seq_err, dwell_err, locked, rotations),
              pack(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        repeat (2) @(negedge clk);
        check("reset held [colour valid step seq_err dwell_err locked rotations]",
              pack(colour, colour_valid, step, seq_err, dwell_err, locked, rotations),
              pack(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
`ifdef RGB_MON_DWELL_OUT_EN
        check("reset last_dwell", 40'(last_dwell), 40'd0);
`endif
        reset     = 1'b0;
        prev_hold = 0;
        mon_en    = 1'b1;
    endtask

    task automatic run_vectors(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            vec_t       v;
            logic [3:0] cv;
            v  = vecs[k];
            cv = exp_colour(v.rgb);
            for (int i = 0; i < v.hold; i++) begin
                exp_t e;
                logic st, sq, dw, lk;
                st = (i == 0) && v.step;
                sq = (i == 0) && v.seq_err;
                dw = (i == 0) ? v.dwell_err : (i == v.tmo);
                lk = (v.tmo != NONE && i >= v.tmo) ? 1'b0 : v.locked;
                @(negedge clk);
                {red, green, blue} = v.rgb;
                e.vec    = k;
                e.cyc    = i;
                e.outs   = pack(cv[2:0], cv[3], st, sq, dw, lk, v.rot);
                e.chk_ld = (prev_hold != 0);
                e.ld     = 4'((prev_hold > DMAX) ? DMAX : prev_hold);
                exp_q.push_back(e);
            end
            prev_hold = v.hold;
        end
    endtask

    // Output for a code driven at one negedge appears after the second following posedge.
    always @(posedge clk) begin
        exp_t        e;
        logic [39:0] act;
        #1;
        if (mon_en && exp_q.size() >= 2) begin
            e   = exp_q.pop_front();
            act = pack(colour, colour_valid, step, seq_err, dwell_err, locked, rotations);
            check($sformatf("vec%0d.cyc%0d [colour valid step seq_err dwell_err locked rotations]",
                            e.vec, e.cyc), act, e.outs);
`ifdef RGB_MON_DWELL_OUT_EN
            if (e.chk_ld)
                check($sformatf("vec%0d.cyc%0d last_dwell", e.vec, e.cyc),
                      40'(last_dwell), 40'(e.ld));
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        {red, green, blue} = BLK;

        //  code hold step seq dwell tmo   locked rot
        add(RED, 10, 0, 0, 0, NONE, 0, 0);  // first change: SEARCH -> TRACK, no check
        add(YEL, 10, 1, 0, 0, NONE, 0, 0);
        add(GRN, 10, 1, 0, 0, NONE, 0, 0);
        add(CYN, 10, 1, 0, 0, NONE, 1, 0);  // third step locks
        add(BLU, 10, 1, 0, 0, NONE, 1, 0);
        add(MAG, 10, 1, 0, 0, NONE, 1, 0);
        add(RED, 10, 1, 0, 0, NONE, 1, 1);  // MAGENTA->RED while locked
        add(YEL,  9, 1, 0, 0, NONE, 1, 1);
        add(GRN, 11, 1, 0, 0, NONE, 1, 1);  // YEL dwell 9 accepted
        add(CYN, 10, 1, 0, 0, NONE, 1, 1);  // GRN dwell 11 accepted
        add(BLU,  8, 1, 0, 0, NONE, 1, 1);
        add(MAG, 10, 0, 0, 1, NONE, 0, 1);  // BLU dwell 8 rejected
        add(RED, 10, 0, 0, 0, NONE, 0, 1);  // restart, no rotation from SEARCH
        add(YEL, 10, 1, 0, 0, NONE, 0, 1);
        add(GRN, 10, 1, 0, 0, NONE, 0, 1);
        add(CYN, 10, 1, 0, 0, NONE, 1, 1);
        add(BLU, 10, 1, 0, 0, NONE, 1, 1);
        add(MAG, 10, 1, 0, 0, NONE, 1, 1);
        add(RED, 12, 1, 0, 0,   11, 1, 2);  // stuck RED: timeout on 12th cycle
        add(YEL, 10, 0, 0, 0, NONE, 0, 2);
        add(GRN, 10, 1, 0, 0, NONE, 0, 2);
        add(CYN, 10, 1, 0, 0, NONE, 0, 2);
        add(BLU, 10, 1, 0, 0, NONE, 1, 2);
        add(MAG, 10, 1, 0, 0, NONE, 1, 2);
        add(RED, 10, 1, 0, 0, NONE, 1, 3);
        add(GRN, 10, 0, 1, 0, NONE, 0, 3);  // RED->GREEN out of order
        add(CYN, 10, 0, 0, 0, NONE, 0, 3);
        add(BLU, 10, 1, 0, 0, NONE, 0, 3);
        add(MAG, 10, 1, 0, 0, NONE, 0, 3);
        add(RED, 10, 1, 0, 0, NONE, 1, 3);  // locks in TRACK: no rotation counted
        add(YEL, 10, 1, 0, 0, NONE, 1, 3);
        add(BLK,  5, 0, 1, 0, NONE, 0, 3);  // illegal 000 while locked: one seq_err
        add(GRN, 10, 0, 0, 0, NONE, 0, 3);
        add(CYN, 10, 1, 0, 0, NONE, 0, 3);
        add(WHT,  3, 0, 1, 0, NONE, 0, 3);  // illegal 111 while tracking
        add(CYN, 10, 0, 0, 0, NONE, 0, 3);  // same-code re-entry restarts
        add(BLU, 10, 1, 0, 0, NONE, 0, 3);
        add(MAG, 10, 1, 0, 0, NONE, 0, 3);
        add(RED, 10, 1, 0, 0, NONE, 1, 3);
        add(YEL,  7, 1, 0, 0, NONE, 1, 3);
        add(CYN, 10, 0, 1, 0, NONE, 0, 3);  // wrong successor and bad dwell: seq_err only
        add(BLU, 10, 0, 0, 0, NONE, 0, 3);
        add(MAG, 10, 1, 0, 0, NONE, 0, 3);
        add(RED, 10, 1, 0, 0, NONE, 0, 3);
        add(YEL, 10, 1, 0, 0, NONE, 1, 3);
        add(GRN, 10, 1, 0, 0, NONE, 1, 3);
        split = vecs.size();
        add(RED, 10, 0, 0, 0, NONE, 0, 0);  // after mid-lock reset: history gone
        add(YEL, 10, 1, 0, 0, NONE, 0, 0);
        add(GRN, 10, 1, 0, 0, NONE, 0, 0);
        add(CYN, 10, 1, 0, 0, NONE, 1, 0);
        add(BLU,  5, 1, 0, 0, NONE, 1, 0);

        apply_reset();
        run_vectors(0, split - 1);
        apply_reset();
        run_vectors(split, vecs.size() - 1);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
